adder_client: RTL
=================

# adder_client

Initiator-side endpoint for the NoC adder accelerator. It accepts an operand pair on a local command port and sends it as a two-beat AXI-Stream packet to the adder's node. It then waits for the single-beat sum and returns it on a local response port, flagged for arithmetic mismatch or timeout. It sits at the node the adder replies to (default TDEST 3).

## Interface
- TDATAW, 32, stream and operand data width
- TDESTW, 4, NoC destination width
- TIDW, 2, stream ID width
- ADDER_DEST, 4'b0010, TDEST of the adder node
- SRC_ID, 2'b00, TID driven on outgoing beats
- TIMEOUT, 256, cycles to wait for a result; 0 disables timeout
- CLK  in  1  clock, single clock domain
- RST_N  in  1  reset, asynchronous, active-low
- CMD_VALID  in  1  operand pair valid
- CMD_READY  out  1  command accepted when VALID&&READY
- CMD_A  in  TDATAW  first operand
- CMD_B  in  TDATAW  second operand
- RSP_VALID  out  1  result valid, held until RSP_READY
- RSP_READY  in  1  response consumer ready
- RSP_DATA  out  TDATAW  received sum (0 on timeout)
- RSP_MISMATCH  out  1  received sum differs from local A+B
- RSP_TIMEOUT  out  1  no result within TIMEOUT cycles
- STRAY_CNT  out  8  saturating count of unsolicited beats
- AXIS_M_TVALID / TREADY / TDATA[TDATAW] / TLAST / TID[TIDW] / TDEST[TDESTW]  out/in/out/out/out/out  master stream to NoC
- AXIS_S_TVALID / TREADY / TDATA[TDATAW] / TLAST / TID[TIDW] / TDEST[TDESTW]  in/out/in/in/in/in  slave stream from NoC

## Operation
- Decided: one clock CLK; RST_N asynchronous, active-low.
- States:
  - IDLE: CMD_READY=1. On CMD handshake, register A, B and EXP=A+B (mod 2^TDATAW), then go to SEND_A.
  - SEND_A: M_TVALID=1, TDATA=A, TLAST=0. On M_TREADY, go to SEND_B.
  - SEND_B: M_TVALID=1, TDATA=B, TLAST=1. On M_TREADY, go to WAIT_RESULT and clear the timer.
  - WAIT_RESULT: S_TREADY=1. On S_TVALID, capture TDATA, set MISMATCH=(TDATA!=EXP), go to RESPOND. Otherwise increment the timer. When timer==TIMEOUT-1 (TIMEOUT≠0), set TIMEOUT flag, DATA=0, go to RESPOND.
  - RESPOND: RSP_VALID=1. On RSP_READY, go to IDLE.
- TDEST=ADDER_DEST and TID=SRC_ID whenever M_TVALID=1. Master outputs are 0 when M_TVALID=0.
- Master outputs are held stable while TVALID=1 and TREADY=0.
- S_TREADY is also 1 in IDLE, SEND_A, SEND_B and RESPOND. Beats accepted there are discarded and increment STRAY_CNT, which saturates at 255.
- A late result arriving after a timeout is counted as stray.
- Incoming TID, TDEST and TLAST are ignored.
- Simultaneous S_TVALID and timer expiry in WAIT_RESULT: the beat wins, TIMEOUT=0.
- RSP_MISMATCH and RSP_TIMEOUT are never both 1.

## Timing
- Reset values: all outputs 0 except CMD_READY=1 and S_TREADY=1. State is IDLE, timer 0, STRAY_CNT 0.
- Reset mid-operation aborts the transaction immediately, with no further beats and no response.
- CMD handshake at cycle n: beat A is valid at n+1; beat B is valid at the cycle after A's handshake. Minimum 2 cycles from command to last beat with no backpressure.
- The result beat handshake at cycle m gives RSP_VALID=1 at m+1.
- Timeout: with B's handshake at cycle k, RSP_VALID rises at k+TIMEOUT+1.
- Only one transaction is outstanding. CMD_READY=0 from acceptance until the RSP handshake.
- All outputs come from registered state. There is no combinational path from S_TVALID or M_TREADY to any output except through state.

## Structure
- Shared package adder_noc_pkg holds:
  - the state_t enum (IDLE, SEND_A, SEND_B, WAIT_RESULT, RESPOND), 3-bit logic;
  - node constants ADDER_NODE=4'b0010 and CLIENT_NODE=4'b0011.
- Parameter defaults reference these node constants.
- Timer width is $clog2(TIMEOUT+1), minimum 1.
- No sub-module; single flat module, roughly 200 lines.

## Test plan
- Reset: assert RST_N=0 mid-WAIT_RESULT -> outputs return to their reset values within the same cycle; no RSP_VALID after release.
- Basic: CMD A=5, B=7; reply 12 -> master beats 5 (TLAST=0) then 7 (TLAST=1) with TDEST=2 and TID=0; RSP_DATA=12, MISMATCH=0, TIMEOUT=0.
- Wrap-around and mismatch:
  - A=0xFFFFFFFF, B=1, reply 0 -> MISMATCH=0.
  - Next transaction A=3, B=4, reply 8 -> RSP_DATA=8, MISMATCH=1.
- Backpressure: hold M_TREADY=0 for 5 cycles on each beat -> TDATA and TLAST stay stable; exactly 2 beats are sent.
- Timeout: TIMEOUT=16, no reply -> RSP_VALID at cycle B-handshake+17 with TIMEOUT=1, DATA=0. Then inject the late beat -> STRAY_CNT=1.
- Stray and simultaneous events:
  - 300 beats in IDLE -> STRAY_CNT=255.
  - Result beat on the expiry cycle -> TIMEOUT=0 and data captured.
  - RSP_READY held 0 for 10 cycles -> RSP fields stable.

Source files
------------

// File: rtl/adder_noc_pkg.sv
// Shared definitions for the NoC adder accelerator and its clients:
// the client FSM state encoding and the node addresses on the NoC.
package adder_noc_pkg;

  typedef enum logic [2:0] {
    IDLE,
    SEND_A,
    SEND_B,
    WAIT_RESULT,
    RESPOND
  } state_t;

  localparam logic [3:0] ADDER_NODE  = 4'b0010;
  localparam logic [3:0] CLIENT_NODE = 4'b0011;

endpackage

// File: rtl/adder_client.sv
// Initiator endpoint for the NoC adder: sends an operand pair as a two-beat
// packet, waits for the single-beat sum and reports it with mismatch/timeout flags.
module adder_client
  import adder_noc_pkg::*;
#(
  parameter int                 TDATAW     = 32,
  parameter int                 TDESTW     = 4,
  parameter int                 TIDW       = 2,
  parameter logic [TDESTW-1:0]  ADDER_DEST = TDESTW'(ADDER_NODE),
  parameter logic [TIDW-1:0]    SRC_ID     = '0,
  parameter int                 TIMEOUT    = 256
) (
  input  logic              CLK,
  input  logic              RST_N,

  input  logic              CMD_VALID,
  output logic              CMD_READY,
  input  logic [TDATAW-1:0] CMD_A,
  input  logic [TDATAW-1:0] CMD_B,

  output logic              RSP_VALID,
  input  logic              RSP_READY,
  output logic [TDATAW-1:0] RSP_DATA,
  output logic              RSP_MISMATCH,
  output logic              RSP_TIMEOUT,
  output logic [7:0]        STRAY_CNT,

  output logic              AXIS_M_TVALID,
  input  logic              AXIS_M_TREADY,
  output logic [TDATAW-1:0] AXIS_M_TDATA,
  output logic              AXIS_M_TLAST,
  output logic [TIDW-1:0]   AXIS_M_TID,
  output logic [TDESTW-1:0] AXIS_M_TDEST,

  input  logic              AXIS_S_TVALID,
  output logic              AXIS_S_TREADY,
  input  logic [TDATAW-1:0] AXIS_S_TDATA,
  input  logic              AXIS_S_TLAST,
  input  logic [TIDW-1:0]   AXIS_S_TID,
  input  logic [TDESTW-1:0] AXIS_S_TDEST
);

  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_t            state, state_next;
  logic [TDATAW-1:0] a_reg, b_reg, exp_reg;
  logic [TDATAW-1:0] rsp_data;
  logic              rsp_mismatch, rsp_timeout;
  logic [TW-1:0]     timer, timer_next;
  logic [7:0]        stray_cnt;

  logic load_cmd, capture, expire, stray_inc, timer_expired;
  logic m_valid;

  // Sideband fields of the reply are not used; the sum is matched by state alone.
  logic unused_s_sideband;
  assign unused_s_sideband = ^{AXIS_S_TLAST, AXIS_S_TID, AXIS_S_TDEST};

  assign timer_expired = (TIMEOUT != 0) && (timer == TW'(TIMEOUT - 1));

  always_comb begin
    state_next = state;
    timer_next = timer;
    load_cmd   = 1'b0;
    capture    = 1'b0;
    expire     = 1'b0;
    case (state)
      IDLE: begin
        if (CMD_VALID) begin
          load_cmd   = 1'b1;
          state_next = SEND_A;
        end
      end
      SEND_A: begin
        if (AXIS_M_TREADY) state_next = SEND_B;
      end
      SEND_B: begin
        if (AXIS_M_TREADY) begin
          state_next = WAIT_RESULT;
          timer_next = '0;
        end
      end
      WAIT_RESULT: begin
        // A beat on the expiry cycle takes priority over the timeout.
        if (AXIS_S_TVALID) begin
          capture    = 1'b1;
          state_next = RESPOND;
        end else if (timer_expired) begin
          expire     = 1'b1;
          state_next = RESPOND;
        end else begin
          timer_next = timer + 1'b1;
        end
      end
      RESPOND: begin
        if (RSP_READY) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    stray_inc = AXIS_S_TVALID && (state != WAIT_RESULT);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state        <= IDLE;
      timer        <= '0;
      a_reg        <= '0;
      b_reg        <= '0;
      exp_reg      <= '0;
      rsp_data     <= '0;
      rsp_mismatch <= 1'b0;
      rsp_timeout  <= 1'b0;
      stray_cnt    <= '0;
    end else begin
      state <= state_next;
      timer <= timer_next;
      if (load_cmd) begin
        a_reg   <= CMD_A;
        b_reg   <= CMD_B;
        exp_reg <= CMD_A + CMD_B;
      end
      if (capture) begin
        rsp_data     <= AXIS_S_TDATA;
        rsp_mismatch <= (AXIS_S_TDATA != exp_reg);
        rsp_timeout  <= 1'b0;
      end else if (expire) begin
        rsp_data     <= '0;
        rsp_mismatch <= 1'b0;
        rsp_timeout  <= 1'b1;
      end
      if (stray_inc && (stray_cnt != 8'hFF)) stray_cnt <= stray_cnt + 1'b1;
    end
  end

  assign m_valid       = (state == SEND_A) || (state == SEND_B);
  assign CMD_READY     = (state == IDLE);
  assign AXIS_S_TREADY = 1'b1;

  assign AXIS_M_TVALID = m_valid;
  assign AXIS_M_TDATA  = (state == SEND_A) ? a_reg :
                         (state == SEND_B) ? b_reg : '0;
  assign AXIS_M_TLAST  = (state == SEND_B);
  assign AXIS_M_TID    = m_valid ? SRC_ID : '0;
  assign AXIS_M_TDEST  = m_valid ? ADDER_DEST : '0;

  assign RSP_VALID     = (state == RESPOND);
  assign RSP_DATA      = RSP_VALID ? rsp_data : '0;
  assign RSP_MISMATCH  = RSP_VALID && rsp_mismatch;
  assign RSP_TIMEOUT   = RSP_VALID && rsp_timeout;
  assign STRAY_CNT     = stray_cnt;

endmodule
